// File: rtl/player_mover.sv
// Player position/colour generator: synchronised one-hot buttons drive single
// steps with auto-repeat and screen wrap; a separate button cycles the colour.
//
// state | meaning
// IDLE  | no valid direction seen; next valid press steps at once
// HOLD  | a direction is held; repeat step every STEP_DIV cycles
module player_mover #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned PLAYER_SIZE = 12,
  parameter int unsigned H_START     = 314,
  parameter int unsigned V_START     = 234,
  parameter int unsigned STEP_DIV    = 4,
  parameter int unsigned NUM_COLORS  = 8
) (
  input  logic        btnClk,
  input  logic        rst,
  input  logic [3:0]  btns,
  input  logic        btnC,
  input  logic        upBlock,
  input  logic        downBlock,
  input  logic        leftBlock,
  input  logic        rightBlock,
  output logic [31:0] player_hPos,
  output logic [31:0] player_vPos,
  output logic [3:0]  player_color,
  output logic        moving
);

  localparam logic [31:0] H_MAX = 32'(H_RES - PLAYER_SIZE);
  localparam logic [31:0] V_MAX = 32'(V_RES - PLAYER_SIZE);
  localparam int          CW    = $clog2(STEP_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STEP_DIV - 1);
  localparam logic [3:0]    COLOR_LAST = 4'(NUM_COLORS - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state;
  logic [3:0]    dir_q;
  logic [CW-1:0] cnt;
  logic [3:0]    btns_meta, sbtns;
  logic          btnc_meta, sbtnC, sbtnC_d;

  logic          dir_valid;
  logic          blocked;
  logic          want_step;
  logic          do_step;
  logic [31:0]   next_h, next_v;

  always_ff @(posedge btnClk or negedge rst) begin
    if (!rst) begin
      btns_meta <= '0;
      sbtns     <= '0;
      btnc_meta <= 1'b0;
      sbtnC     <= 1'b0;
      sbtnC_d   <= 1'b0;
    end else begin
      btns_meta <= btns;
      sbtns     <= btns_meta;
      btnc_meta <= btnC;
      sbtnC     <= btnc_meta;
      sbtnC_d   <= sbtnC;
    end
  end

  // Candidate position for the direction currently on sbtns, wrap included.
  always_comb begin
    dir_valid = 1'b0;
    blocked   = 1'b0;
    next_h    = player_hPos;
    next_v    = player_vPos;
    case (sbtns)
      4'b1000: begin
        dir_valid = 1'b1;
        blocked   = upBlock;
        next_v    = (player_vPos == 32'd0) ? V_MAX : player_vPos - 32'd1;
      end
      4'b0100: begin
        dir_valid = 1'b1;
        blocked   = downBlock;
        next_v    = (player_vPos == V_MAX) ? 32'd0 : player_vPos + 32'd1;
      end
      4'b0010: begin
        dir_valid = 1'b1;
        blocked   = rightBlock;
        next_h    = (player_hPos == H_MAX) ? 32'd0 : player_hPos + 32'd1;
      end
      4'b0001: begin
        dir_valid = 1'b1;
        blocked   = leftBlock;
        next_h    = (player_hPos == 32'd0) ? H_MAX : player_hPos - 32'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    want_step = dir_valid && ((state == IDLE) || (sbtns != dir_q) || (cnt == CNT_LAST));
    do_step   = want_step && !blocked;
  end

  always_ff @(posedge btnClk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      dir_q       <= '0;
      cnt         <= '0;
      player_hPos <= 32'(H_START);
      player_vPos <= 32'(V_START);
      moving      <= 1'b0;
    end else begin
      moving <= do_step;
      if (do_step) begin
        player_hPos <= next_h;
        player_vPos <= next_v;
      end
      case (state)
        IDLE: begin
          if (dir_valid) begin
            dir_q <= sbtns;
            cnt   <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!dir_valid) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (sbtns != dir_q) begin
            dir_q <= sbtns;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            // Reloads even when the step was blocked: retry waits a full slot.
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge btnClk or negedge rst) begin
    if (!rst) begin
      player_color <= '0;
    end else if (sbtnC && !sbtnC_d) begin
      player_color <= (player_color == COLOR_LAST) ? 4'd0 : player_color + 4'd1;
    end
  end

endmodule

// File: tb/tb_player_mover.sv
// Scoreboard bench for player_mover: a per-edge reference model pushes the
// expected outputs, a monitor pops and compares them after each clock edge.
module tb_player_mover;
  localparam int H_RES = 640, V_RES = 480, PSZ = 12;
  localparam int H_START = 314, V_START = 234, STEP_DIV = 4, NUM_COLORS = 8;
  localparam int H_MAX = H_RES - PSZ, V_MAX = V_RES - PSZ;

  logic        btnClk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btns = 4'd0;
  logic        btnC = 1'b0;
  logic        upBlock = 1'b0, downBlock = 1'b0, leftBlock = 1'b0, rightBlock = 1'b0;
  logic [31:0] player_hPos, player_vPos;
  logic [3:0]  player_color;
  logic        moving;

  player_mover #(
    .H_RES(H_RES), .V_RES(V_RES), .PLAYER_SIZE(PSZ), .H_START(H_START),
    .V_START(V_START), .STEP_DIV(STEP_DIV), .NUM_COLORS(NUM_COLORS)
  ) dut (
    .btnClk(btnClk), .rst(rst), .btns(btns), .btnC(btnC),
    .upBlock(upBlock), .downBlock(downBlock), .leftBlock(leftBlock), .rightBlock(rightBlock),
    .player_hPos(player_hPos), .player_vPos(player_vPos),
    .player_color(player_color), .moving(moving)
  );

  always #5 btnClk = ~btnClk;

  typedef struct {
    int h;
    int v;
    int c;
    int m;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int passed = 0;

  // Reference model: raw button history (two-edge sync delay), run length of
  // the same valid direction, and the resulting position/colour.
  int         m_h = H_START, m_v = V_START, m_c = 0, m_mov = 0;
  int         run_len = 0;
  bit         run_active = 0;
  logic [3:0] run_dir = 4'd0;
  logic [3:0] hb1 = 4'd0, hb2 = 4'd0;
  bit         hc1 = 0, hc2 = 0, hc3 = 0;
  bit         cur_c = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic bit one_hot_dir(input logic [3:0] b);
    return (b == 4'd8) || (b == 4'd4) || (b == 4'd2) || (b == 4'd1);
  endfunction

  // Drives one cycle of inputs, models the coming edge, waits to the next negedge.
  task automatic cyc(input logic [3:0] b, input bit c, input bit u, input bit d,
                     input bit l, input bit r, input bit rv);
    exp_t e;
    bit   step;
    if (!rv && rst) begin
      rst = 1'b0;
      #1;
      chk("async_rst_h", player_hPos, H_START);
      chk("async_rst_v", player_vPos, V_START);
      chk("async_rst_color", player_color, 0);
      chk("async_rst_moving", moving, 0);
    end else begin
      rst = rv;
    end
    btns = b; btnC = c;
    upBlock = u; downBlock = d; leftBlock = l; rightBlock = r;

    if (!rv) begin
      m_h = H_START; m_v = V_START; m_c = 0; m_mov = 0;
      run_active = 0; run_len = 0; run_dir = 4'd0;
      hb1 = 4'd0; hb2 = 4'd0; hc1 = 0; hc2 = 0; hc3 = 0;
    end else begin
      step = 0;
      if (one_hot_dir(hb2)) begin
        if (run_active && run_dir == hb2) run_len++;
        else begin
          run_active = 1; run_dir = hb2; run_len = 0;
        end
        step = (run_len % STEP_DIV) == 0;
      end else begin
        run_active = 0;
      end
      m_mov = 0;
      if (step) begin
        case (hb2)
          4'd8: if (!u) begin m_v = (m_v == 0) ? V_MAX : m_v - 1; m_mov = 1; end
          4'd4: if (!d) begin m_v = (m_v == V_MAX) ? 0 : m_v + 1; m_mov = 1; end
          4'd2: if (!r) begin m_h = (m_h == H_MAX) ? 0 : m_h + 1; m_mov = 1; end
          4'd1: if (!l) begin m_h = (m_h == 0) ? H_MAX : m_h - 1; m_mov = 1; end
          default: ;
        endcase
      end
      if (hc2 && !hc3) m_c = (m_c + 1) % NUM_COLORS;
      hb2 = hb1; hb1 = b;
      hc3 = hc2; hc2 = hc1; hc1 = c;
    end
    e.h = m_h; e.v = m_v; e.c = m_c; e.m = m_mov;
    exp_q.push_back(e);
    @(negedge btnClk);
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) cyc(b, cur_c, 0, 0, 0, 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge btnClk);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL no_expectation actual=empty required=entry at t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("hpos", player_hPos, e.h);
        chk("vpos", player_vPos, e.v);
        chk("color", player_color, e.c);
        chk("moving", moving, e.m);
      end
    end
  end

  initial begin : driver
    logic [3:0] pool [9];
    logic [3:0] rb;
    int         len;
    pool[0] = 4'd0; pool[1] = 4'd1; pool[2] = 4'd2; pool[3] = 4'd4; pool[4] = 4'd8;
    pool[5] = 4'd6; pool[6] = 4'd3; pool[7] = 4'd12; pool[8] = 4'd15;

    #1 rst = 1'b0;
    #1;
    chk("init_rst_h", player_hPos, H_START);
    chk("init_rst_v", player_vPos, V_START);
    chk("init_rst_color", player_color, 0);
    chk("init_rst_moving", moving, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    hold(4'd8, 1);
    hold(4'd0, 4);
    chk("single_up_v", player_vPos, 233);
    chk("single_up_h", player_hPos, 314);

    hold(4'd2, 14);
    hold(4'd0, 4);
    chk("repeat_right_h", player_hPos, 318);

    hold(4'd2, 4 * 309 + 1);
    hold(4'd0, 4);
    chk("right_edge_h", player_hPos, H_MAX);
    hold(4'd2, 1);
    hold(4'd0, 4);
    chk("wrap_right_h", player_hPos, 0);
    hold(4'd1, 1);
    hold(4'd0, 4);
    chk("wrap_left_h", player_hPos, H_MAX);

    hold(4'd8, 4 * 232 + 1);
    hold(4'd0, 4);
    chk("top_edge_v", player_vPos, 0);
    hold(4'd8, 1);
    hold(4'd0, 4);
    chk("wrap_up_v", player_vPos, V_MAX);
    hold(4'd4, 1);
    hold(4'd0, 4);
    chk("wrap_down_v", player_vPos, 0);

    for (int i = 0; i < 20; i++) cyc(4'd4, cur_c, 0, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(4'd4, cur_c, 0, 0, 0, 0, 1);
    hold(4'd6, 8);
    hold(4'd0, 3);
    hold(4'd8, 7);
    hold(4'd1, 9);
    hold(4'd0, 4);

    cur_c = 1; hold(4'd0, 10);
    cur_c = 0; hold(4'd0, 4);
    chk("color_one_inc", player_color, 1);
    for (int i = 0; i < 7; i++) begin
      cur_c = 1; hold(4'd0, 2);
      cur_c = 0; hold(4'd0, 2);
    end
    hold(4'd0, 2);
    chk("color_wrap", player_color, 0);

    hold(4'd2, 10);
    cyc(4'd2, 0, 0, 0, 0, 0, 0);
    cyc(4'd2, 0, 0, 0, 0, 0, 0);
    hold(4'd2, 10);
    hold(4'd0, 4);

    for (int k = 0; k < 400; k++) begin
      rb  = pool[$urandom_range(0, 8)];
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 5) == 0) cur_c = ~cur_c;
        cyc(rb, cur_c, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 299) != 0);
      end
    end
    hold(4'd0, 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/player_mover.md
Name: player_mover

Overview:
- Upstream stage for the rectangle obstacle blocks.
- Turns raw one-hot push-button input into the player's position (player_hPos, player_vPos) and colour (player_color), which every rectangle consumes.
- Honours the per-direction block flags that the rectangles produce (their up/down/left/right outputs, OR-reduced at top level).
- Provides single-step on press, auto-repeat on hold, screen wrap-around and colour cycling.

Parameters:
- H_RES, 640, horizontal screen size in pixels.
- V_RES, 480, vertical screen size in pixels.
- PLAYER_SIZE, 12, player square edge in pixels.
- H_START, 314, reset horizontal position.
- V_START, 234, reset vertical position.
- STEP_DIV, 4, cycles between auto-repeat steps while a button is held (>=2).
- NUM_COLORS, 8, number of player colours (<=16).

Ports:
- btnClk  in  1  single clock, also the movement tick.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- btns  in  4  raw buttons, one-hot: 8=up, 4=down, 2=right, 1=left.
- btnC  in  1  raw colour-cycle button.
- upBlock  in  1  1 = upward move forbidden this cycle.
- downBlock  in  1  1 = downward move forbidden.
- leftBlock  in  1  1 = leftward move forbidden.
- rightBlock  in  1  1 = rightward move forbidden.
- player_hPos  out  32  player left edge, 0..H_RES-PLAYER_SIZE.
- player_vPos  out  32  player top edge, 0..V_RES-PLAYER_SIZE.
- player_color  out  4  current player colour, 0..NUM_COLORS-1.
- moving  out  1  one-cycle pulse after each successful step.

Behaviour:
- Reset (rst=0, async):
  - player_hPos=H_START, player_vPos=V_START, player_color=0, moving=0.
  - FSM=IDLE, repeat counter=0, all synchroniser flops=0.
- Synchronisers: btns and btnC each pass through a 2-flop synchroniser. The FSM sees only the synchronised values (sbtns, sbtnC).
- Valid direction: sbtns is exactly one of 8/4/2/1. Zero or multi-bit values are "no direction".
- Step(dir):
  - Executed on a clock edge. If the matching block input is 1 on that edge, position holds and moving<=0.
  - Otherwise position updates by 1 pixel with wrap-around, and moving<=1.
  - moving<=0 on every edge without a successful step.
- Wrap rules:
  - up at vPos=0 -> V_RES-PLAYER_SIZE; down at V_RES-PLAYER_SIZE -> 0.
  - left at hPos=0 -> H_RES-PLAYER_SIZE; right at H_RES-PLAYER_SIZE -> 0.
  - Otherwise ±1.
  - Outputs never leave the legal range. Arithmetic is unsigned 32-bit.
- FSM states: IDLE, HOLD.
  - IDLE, valid dir: latch dir, Step(dir), counter<=0, go HOLD.
  - IDLE, no direction: stay IDLE.
  - HOLD, sbtns == latched dir:
    - counter<STEP_DIV-1: counter++.
    - counter==STEP_DIV-1: Step(dir), counter<=0.
  - HOLD, sbtns is a different valid dir: latch new dir, Step(new), counter<=0, stay HOLD.
  - HOLD, no direction: go IDLE, counter<=0, no step.
- Blocked step in HOLD: the counter still reloads to 0. Retry happens at the next repeat slot, not every cycle.
- Latency: raw btns change sampled at edge k. Position/moving updated at edge k+2, visible after k+2.
- Colour:
  - Rising edge of sbtnC (sbtnC=1, previous sbtnC=0): player_color<=player_color+1, wrapping NUM_COLORS-1 -> 0.
  - Held btnC gives exactly one increment.
  - Colour change and step on the same edge both take effect.
  - Block inputs on that edge reflect the old colour (one-cycle feedback lag accepted).
- Reset mid-HOLD: immediate return to reset values. After release, a button still held is treated as a fresh press: one step 2 edges after first sampled, then repeat.

Test Plan:
- Reset, then btns=8 held 1 cycle (synced) -> vPos 234->233 at edge k+2, moving pulses 1 cycle, returns to IDLE, hPos stays 314.
- Hold btns=2 for 14 edges, STEP_DIV=4 -> hPos 314 -> 318 (steps at relative edges 2,6,10,14), moving high exactly 4 single cycles.
- Wrap: force hPos to 628 and press right -> hPos=0. Then press left -> hPos=628. Likewise vPos 0 with up -> 468.
- Blocking: btns=4 held with downBlock=1 -> vPos constant, moving=0. Drop downBlock -> next repeat slot steps vPos+1.
- btns=6 (invalid) or 0 -> no movement. Switch held 8->1 in HOLD -> immediate left step, counter restarts.
- btnC held 10 cycles -> player_color 0->1 once. Repeat 8 presses -> wraps to 0. Assert rst=0 mid-HOLD -> outputs 314/234/0 asynchronously.
